// File: rtl/stack_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of a small LIFO stack.
// One request is in flight at a time; occupancy is tracked here so that
// overflow, underflow and out-of-range GET are rejected before reaching the stack.
module stack_arbiter #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [1:0]       req0_command,
    input  logic [2:0]       req0_index,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [1:0]       req1_command,
    input  logic [2:0]       req1_index,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_error,
    output logic [1:0]       stk_command,
    output logic [2:0]       stk_index,
    output logic [WIDTH-1:0] stk_wdata,
    output logic             stk_wdrive,
    input  logic [WIDTH-1:0] stk_rdata,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_PUSH = 2'b01;
    localparam logic [1:0] CMD_POP  = 2'b10;
    localparam logic [1:0] CMD_GET  = 2'b11;
    localparam logic [2:0] DEPTH_C  = 3'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state;
    logic             last_grant;
    logic [1:0]       lat_cmd;
    logic             lat_err;
    logic             lat_id;

    logic             grant0;
    logic             grant1;
    logic [1:0]       sel_cmd;
    logic [2:0]       sel_index;
    logic [WIDTH-1:0] sel_data;
    logic             sel_err;

    // Round-robin grant in IDLE: a lone requester wins, on a tie the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Select the winning request and pre-validate it against the current occupancy,
    // which cannot change before the ISSUE cycle.
    always_comb begin
        sel_cmd   = grant1 ? req1_command : req0_command;
        sel_index = grant1 ? req1_index   : req0_index;
        sel_data  = grant1 ? req1_data    : req0_data;
        sel_err   = 1'b0;
        case (sel_cmd)
            CMD_PUSH: sel_err = (count == DEPTH_C);
            CMD_POP:  sel_err = (count == 3'd0);
            CMD_GET:  sel_err = (sel_index >= count);
            default:  sel_err = 1'b0;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign full       = (count == DEPTH_C);
    assign empty      = (count == 3'd0);

    // Sequencer: latch the grant, drive one stack command, collect read data, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            lat_cmd     <= CMD_NOP;
            lat_err     <= 1'b0;
            lat_id      <= 1'b0;
            count       <= 3'd0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
            rsp_error   <= 1'b0;
            stk_command <= CMD_NOP;
            stk_index   <= 3'd0;
            stk_wdata   <= '0;
            stk_wdrive  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        lat_cmd    <= sel_cmd;
                        lat_err    <= sel_err;
                        lat_id     <= grant1;
                        last_grant <= grant1;
                        if (!sel_err && sel_cmd != CMD_NOP) begin
                            stk_command <= sel_cmd;
                            stk_index   <= sel_index;
                            if (sel_cmd == CMD_PUSH) begin
                                stk_wdata  <= sel_data;
                                stk_wdrive <= 1'b1;
                            end
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stk_command <= CMD_NOP;
                    stk_index   <= 3'd0;
                    stk_wdata   <= '0;
                    stk_wdrive  <= 1'b0;
                    if (!lat_err && lat_cmd == CMD_PUSH) count <= count + 3'd1;
                    if (!lat_err && lat_cmd == CMD_POP)  count <= count - 3'd1;
                    if (!lat_err && (lat_cmd == CMD_POP || lat_cmd == CMD_GET)) begin
                        state <= ST_WAIT;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= lat_id;
                        rsp_error <= lat_err;
                        rsp_data  <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= lat_id;
                    rsp_error <= 1'b0;
                    rsp_data  <= stk_rdata;
                    state     <= ST_RESP;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_error <= 1'b0;
                    rsp_data  <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small behavioural stack on the command bus.
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_command, req1_command;
    logic [2:0] req0_index, req1_index;
    logic [3:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       rsp_valid, rsp_id, rsp_error;
    logic [3:0] rsp_data;
    logic [1:0] stk_command;
    logic [2:0] stk_index;
    logic [3:0] stk_wdata;
    logic       stk_wdrive;
    logic [3:0] stk_rdata;
    logic [2:0] count;
    logic       full, empty;

    int errors = 0;
    int checks = 0;

    logic [3:0] mem [0:7];
    int         sp;

    stack_arbiter #(.DEPTH(5), .WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_command(req0_command), .req0_index(req0_index),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_command(req1_command), .req1_index(req1_index),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .stk_command(stk_command), .stk_index(stk_index), .stk_wdata(stk_wdata),
        .stk_wdrive(stk_wdrive), .stk_rdata(stk_rdata),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Behavioural stack: acts on the command cycle, read data visible the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            sp        <= 0;
            stk_rdata <= 4'h0;
        end else begin
            case (stk_command)
                2'b01: if (stk_wdrive && sp < 8) begin
                    mem[sp] <= stk_wdata;
                    sp      <= sp + 1;
                end
                2'b10: if (sp > 0) begin
                    stk_rdata <= mem[sp-1];
                    sp        <= sp - 1;
                end
                2'b11: if (sp - 1 - int'(stk_index) >= 0) stk_rdata <= mem[sp-1-int'(stk_index)];
                default: ;
            endcase
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One request from one port, checked through ISSUE, optional WAIT and RESP.
    task automatic applyStimulus(input int port, input logic [1:0] cmd, input logic [2:0] idx,
                                 input logic [3:0] data, input logic expErr, input logic [3:0] expData);
        logic [1:0] expStk;
        logic       longOp;
        logic       got;
        expStk = (expErr || cmd == 2'b00) ? 2'b00 : cmd;
        longOp = !expErr && (cmd == 2'b10 || cmd == 2'b11);
        if (port == 0) begin
            req0_command = cmd; req0_index = idx; req0_data = data; req0_valid = 1'b1;
        end else begin
            req1_command = cmd; req1_index = idx; req1_data = data; req1_valid = 1'b1;
        end
        #1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            if ((port == 0) ? req0_ready : req1_ready) got = 1'b1;
            else begin
                @(posedge clk); #2;
            end
        end
        checkOutput("ready", 8'(got), 8'd1);
        if (got) begin
            @(posedge clk); #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            checkOutput("issue_cmd", 8'(stk_command), 8'(expStk));
            checkOutput("issue_wdrive", 8'(stk_wdrive), 8'(expStk == 2'b01));
            if (expStk == 2'b01) checkOutput("issue_wdata", 8'(stk_wdata), 8'(data));
            if (expStk == 2'b11) checkOutput("issue_index", 8'(stk_index), 8'(idx));
            if (longOp) begin
                @(posedge clk); #1;
                checkOutput("wait_cmd", 8'(stk_command), 8'd0);
                checkOutput("wait_rsp_valid", 8'(rsp_valid), 8'd0);
            end
            @(posedge clk); #1;
            checkOutput("rsp_valid", 8'(rsp_valid), 8'd1);
            checkOutput("rsp_id", 8'(rsp_id), 8'(port));
            checkOutput("rsp_error", 8'(rsp_error), 8'(expErr));
            checkOutput("rsp_data", 8'(rsp_data), 8'(expData));
            @(posedge clk); #1;
            checkOutput("rsp_drop", 8'(rsp_valid), 8'd0);
        end else begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        logic got;
        logic sawRsp;
        reset = 1'b1;
        req0_valid = 1'b0; req0_command = 2'b00; req0_index = 3'd0; req0_data = 4'h0;
        req1_valid = 1'b0; req1_command = 2'b00; req1_index = 3'd0; req1_data = 4'h0;
        resetDut();

        checkOutput("rst_count", 8'(count), 8'd0);
        checkOutput("rst_empty", 8'(empty), 8'd1);
        checkOutput("rst_full", 8'(full), 8'd0);
        checkOutput("rst_ready", 8'({req0_ready, req1_ready}), 8'd0);
        checkOutput("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        checkOutput("rst_rsp_data", 8'(rsp_data), 8'd0);
        checkOutput("rst_stk_cmd", 8'(stk_command), 8'd0);
        checkOutput("rst_wdrive", 8'(stk_wdrive), 8'd0);

        // Two pushes, then drain with pops including one underflow
        applyStimulus(0, 2'b01, 3'd0, 4'hA, 1'b0, 4'h0);
        applyStimulus(0, 2'b01, 3'd0, 4'h3, 1'b0, 4'h0);
        checkOutput("count_after_push2", 8'(count), 8'd2);
        applyStimulus(1, 2'b10, 3'd0, 4'h0, 1'b0, 4'h3);
        checkOutput("count_after_pop1", 8'(count), 8'd1);
        applyStimulus(1, 2'b10, 3'd0, 4'h0, 1'b0, 4'hA);
        checkOutput("count_after_pop2", 8'(count), 8'd0);
        checkOutput("empty_after_pop2", 8'(empty), 8'd1);
        applyStimulus(1, 2'b10, 3'd0, 4'h0, 1'b1, 4'h0);
        checkOutput("count_after_underflow", 8'(count), 8'd0);

        // Fill, overflow, GET at the deepest entry and one past it
        for (int d = 1; d <= 5; d++) applyStimulus(0, 2'b01, 3'd0, 4'(d), 1'b0, 4'h0);
        checkOutput("full_after_5", 8'(full), 8'd1);
        checkOutput("count_after_5", 8'(count), 8'd5);
        applyStimulus(0, 2'b01, 3'd0, 4'hF, 1'b1, 4'h0);
        checkOutput("count_after_overflow", 8'(count), 8'd5);
        applyStimulus(0, 2'b11, 3'd4, 4'h0, 1'b0, 4'h1);
        applyStimulus(0, 2'b11, 3'd0, 4'h0, 1'b0, 4'h5);
        applyStimulus(1, 2'b11, 3'd5, 4'h0, 1'b1, 4'h0);
        applyStimulus(0, 2'b00, 3'd0, 4'h0, 1'b0, 4'h0);
        checkOutput("count_after_get", 8'(count), 8'd5);

        // Both requesters hold PUSH valid: grants alternate starting with 0
        resetDut();
        req0_command = 2'b01; req0_data = 4'h1; req0_valid = 1'b1;
        req1_command = 2'b01; req1_data = 4'h2; req1_valid = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 10 && !got; i++) begin
                if (req0_ready || req1_ready) got = 1'b1;
                else begin
                    @(posedge clk); #2;
                end
            end
            checkOutput("tie_grant0", 8'(req0_ready), 8'(g % 2 == 0));
            checkOutput("tie_grant1", 8'(req1_ready), 8'(g % 2 == 1));
            @(posedge clk); #1;
            checkOutput("tie_issue_ready", 8'(req0_ready | req1_ready), 8'd0);
            checkOutput("tie_issue_data", 8'(stk_wdata), (g % 2 == 0) ? 8'd1 : 8'd2);
            @(posedge clk); #1;
            checkOutput("tie_rsp_valid", 8'(rsp_valid), 8'd1);
            checkOutput("tie_rsp_id", 8'(rsp_id), 8'(g % 2));
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checkOutput("tie_count", 8'(count), 8'd4);

        // Reset during WAIT of a POP drops the response
        req1_command = 2'b10; req1_valid = 1'b1;
        #1;
        checkOutput("rpop_ready", 8'(req1_ready), 8'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        checkOutput("rpop_issue", 8'(stk_command), 8'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("rpop_rsp_valid", 8'(rsp_valid), 8'd0);
        checkOutput("rpop_count", 8'(count), 8'd0);
        checkOutput("rpop_empty", 8'(empty), 8'd1);
        checkOutput("rpop_stk_cmd", 8'(stk_command), 8'd0);
        checkOutput("rpop_rsp_data", 8'(rsp_data), 8'd0);
        sawRsp = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rsp_valid) sawRsp = 1'b1;
        end
        checkOutput("rpop_no_rsp", 8'(sawRsp), 8'd0);
        req0_command = 2'b01; req0_data = 4'h7; req0_valid = 1'b1;
        req1_command = 2'b01; req1_data = 4'h8; req1_valid = 1'b1;
        #1;
        checkOutput("rpop_tie0", 8'(req0_ready), 8'd1);
        checkOutput("rpop_tie1", 8'(req1_ready), 8'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rpop_push_rsp", 8'(rsp_valid), 8'd1);
        checkOutput("rpop_push_id", 8'(rsp_id), 8'd0);
        checkOutput("rpop_push_count", 8'(count), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
